// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store front end for a word-organised data RAM. Takes one byte-addressed
//   MIPS load/store at a time (LB/LBU/LH/LHU/LW/SB/SH/SW), turns it into
//   word-indexed RAM cycles on a shared tri-state bus, merges sub-word stores
//   into the existing word (read-modify-write) and extends sub-word loads.
//
// Ports
//   CLK, Rst            clock (rising edge) / asynchronous active-high reset
//   req_valid/req_ready request handshake; accepted when both are high
//   req_we              1 = store, 0 = load
//   req_size            00 byte, 01 half, 10 word, 11 reserved (fault)
//   req_unsigned        loads: 1 = zero-extend, 0 = sign-extend
//   req_addr            byte address
//   req_wdata           store data, right-aligned
//   resp_valid          one-cycle completion pulse
//   resp_rdata          extended load result (0 for stores and faults), held
//   resp_err            fault flag (size/alignment/range), held
//   mem_addr            RAM word index, zero-extended
//   mem_data            RAM data bus, driven only while mem_rw = 1
//   mem_rw, mem_cs      RAM direction (1 = write) and chip select
//
// Build option
//   MEM_MISALIGN_TRAP_EN  defined: misaligned half/word accesses fault.
//                         undefined: the low address bits are forced to
//                         alignment and the access proceeds.

module mem_access_unit #(
    parameter int WORD_ADDR_W = 12,
    parameter bit BIG_ENDIAN  = 1'b1
) (
    input  logic        CLK,
    input  logic        Rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    inout  wire  [31:0] mem_data,
    output logic        mem_rw,
    output logic        mem_cs
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    localparam int AW = WORD_ADDR_W + 2;

    state_t          state_q, state_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic            we_q, we_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdword_q, rdword_d;

    logic            fault;
    logic            range_err;
    logic [AW-1:0]   addr_aligned;
    logic [31:0]     wr_word;

    // Bit position of the addressed lane inside the word.
    function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] a);
        logic [1:0] bidx;
        logic       hidx;
        bidx = BIG_ENDIAN ? ~a : a;
        hidx = BIG_ENDIAN ? ~a[1] : a[1];
        case (size)
            2'b00:   lane_shift = {bidx, 3'b000};
            2'b01:   lane_shift = {hidx, 4'b0000};
            default: lane_shift = 5'd0;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] word, input logic [1:0] size,
                                           input logic uns, input logic [1:0] a);
        logic [31:0] v;
        v = word >> lane_shift(size, a);
        case (size)
            2'b00:   extend = uns ? {24'd0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
            2'b01:   extend = uns ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
            default: extend = word;
        endcase
    endfunction

    // Replace the addressed lane of the old word with the right-aligned store data.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [1:0] size, input logic [1:0] a);
        logic [31:0] mask;
        logic [4:0]  sh;
        case (size)
            2'b00:   mask = 32'h0000_00FF;
            2'b01:   mask = 32'h0000_FFFF;
            default: mask = 32'hFFFF_FFFF;
        endcase
        sh    = lane_shift(size, a);
        merge = (old & ~(mask << sh)) | ((wd & mask) << sh);
    endfunction

    assign range_err = (req_addr >> AW) != 32'd0;

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign;
    assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                      ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    assign fault        = (req_size == 2'b11) || range_err || misalign;
    assign addr_aligned = req_addr[AW-1:0];
`else
    assign fault = (req_size == 2'b11) || range_err;
    always_comb begin
        addr_aligned = req_addr[AW-1:0];
        if (req_size == 2'b01) addr_aligned[0]   = 1'b0;
        if (req_size == 2'b10) addr_aligned[1:0] = 2'b00;
    end
`endif

    always_comb begin
        state_d  = state_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        we_d     = we_q;
        size_d   = size_q;
        uns_d    = uns_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdword_d = rdword_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = addr_aligned;
                    wdata_d = req_wdata;
                    if (fault) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                    end else if (req_we && (req_size == 2'b10)) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                rdword_d = mem_data;
                if (we_q) begin
                    state_d = WR;
                end else begin
                    state_d = RESP;
                    rdata_d = extend(mem_data, size_q, uns_q, addr_q[1:0]);
                    err_d   = 1'b0;
                end
            end
            WR: begin
                state_d = RESP;
                rdata_d = 32'd0;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Request fields and the read word are only meaningful once latched, so
    // they carry no reset.
    always_ff @(posedge CLK) begin
        we_q     <= we_d;
        size_q   <= size_d;
        uns_q    <= uns_d;
        addr_q   <= addr_d;
        wdata_q  <= wdata_d;
        rdword_q <= rdword_d;
    end

    // RAM-side outputs decode straight from the state so a reset drops them at once.
    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = (state_q == RESP);
        mem_cs     = (state_q == RD) || (state_q == WR);
        mem_rw     = (state_q == WR);
        mem_addr   = 32'd0;
        if (mem_cs) mem_addr[WORD_ADDR_W-1:0] = addr_q[AW-1:2];
        resp_rdata = rdata_q;
        resp_err   = err_q;
    end

    assign wr_word  = merge(rdword_q, wdata_q, size_q, addr_q[1:0]);
    assign mem_data = mem_rw ? wr_word : 32'bz;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        CLK = 1'b0;
    logic        Rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    wire  [31:0] mem_data;
    logic        mem_rw;
    logic        mem_cs;

    mem_access_unit #(.WORD_ADDR_W(12), .BIG_ENDIAN(1'b1)) dut (
        .CLK(CLK), .Rst(Rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_rw(mem_rw), .mem_cs(mem_cs)
    );

    always #5 CLK = ~CLK;

    // RAM model
    logic [31:0] ram [0:4095];
    assign mem_data = (mem_cs && !mem_rw) ? ram[mem_addr[11:0]] : 32'bz;
    always @(posedge CLK) if (mem_cs && mem_rw) ram[mem_addr[11:0]] <= mem_data;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          cs;
        int          acc;
    } resp_t;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    resp_t resp_q[$];
    wr_t   wr_q[$];
    int    n_cmp = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    cs_cnt = 0;
    bit    ignore_bus = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: bus activity and responses, checked against the queued expectations.
    always @(negedge CLK) begin
        if (!Rst && !ignore_bus) begin
            if (mem_cs) cs_cnt++;
            chk("rw_without_cs", {31'd0, mem_rw & ~mem_cs}, 32'd0);
            if (mem_cs && mem_rw) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    chk("wr_addr", mem_addr, w.addr);
                    chk("wr_data", mem_data, w.data);
                end
            end
        end
        if (resp_valid) begin
            if (resp_q.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                resp_t r;
                r = resp_q.pop_front();
                chk("rdata", resp_rdata, r.rdata);
                chk("err", {31'd0, resp_err}, {31'd0, r.err});
                chk("latency", cyc - r.acc + 1, r.lat);
                chk("ram_cycles", cs_cnt, r.cs);
            end
            cs_cnt = 0;
        end
    end

    task automatic wait_ready(output bit ok);
        int t;
        t = 0;
        @(negedge CLK);
        while (!req_ready && t < 20) begin
            @(negedge CLK);
            t++;
        end
        ok = req_ready;
        if (!ok) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err,
                         input int lat, input int cs);
        bit    ok;
        resp_t r;
        wait_ready(ok);
        if (!ok) return;
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        r.rdata = exp_rd; r.err = exp_err; r.lat = lat; r.cs = cs; r.acc = cyc + 1;
        resp_q.push_back(r);
        @(posedge CLK);
        #1;
        // Scramble the request fields: the unit must work from its latched copy.
        req_valid = 1'b0; req_we = ~we; req_size = ~sz; req_unsigned = ~uns;
        req_addr = 32'hFFFF_FFFF; req_wdata = $urandom;
    endtask

    task automatic ld(input logic [1:0] sz, input logic uns, input logic [31:0] a,
                      input logic [31:0] exp_rd, input logic exp_err, input int lat, input int cs);
        issue(1'b0, sz, uns, a, 32'h0, exp_rd, exp_err, lat, cs);
    endtask

    task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                      input logic exp_err, input int lat, input int cs,
                      input logic [31:0] waddr, input logic [31:0] wdata);
        wr_t w;
        if (!exp_err) begin
            w.addr = waddr; w.data = wdata;
            wr_q.push_back(w);
        end
        issue(1'b1, sz, 1'b0, a, wd, 32'h0, exp_err, lat, cs);
    endtask

    initial begin
        bit ok;
        int t;
        for (int i = 0; i < 4096; i++) ram[i] = 32'd0;
        #12;
        // Reset state
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", {31'd0, resp_err}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_cs", {31'd0, mem_cs}, 32'd0);
        chk("rst_mem_rw", {31'd0, mem_rw}, 32'd0);
        @(negedge CLK);
        Rst = 1'b0;

        st(2'b10, 32'h10, 32'hDEADBEEF, 1'b0, 2, 1, 32'd4, 32'hDEADBEEF);
        ld(2'b00, 1'b0, 32'h11, 32'hFFFFFFAD, 1'b0, 2, 1);
        ld(2'b00, 1'b1, 32'h11, 32'h000000AD, 1'b0, 2, 1);
        ld(2'b00, 1'b0, 32'h10, 32'hFFFFFFDE, 1'b0, 2, 1);
        st(2'b01, 32'h12, 32'hABCD1234, 1'b0, 3, 2, 32'd4, 32'hDEAD1234);
        ld(2'b01, 1'b0, 32'h12, 32'h00001234, 1'b0, 2, 1);
        ld(2'b01, 1'b0, 32'h10, 32'hFFFFDEAD, 1'b0, 2, 1);
        ld(2'b01, 1'b1, 32'h10, 32'h0000DEAD, 1'b0, 2, 1);
        st(2'b00, 32'h13, 32'h12345699, 1'b0, 3, 2, 32'd4, 32'hDEAD1299);
        ld(2'b00, 1'b0, 32'h13, 32'hFFFFFF99, 1'b0, 2, 1);
        ld(2'b00, 1'b1, 32'h12, 32'h00000012, 1'b0, 2, 1);
        st(2'b00, 32'h10, 32'h00000055, 1'b0, 3, 2, 32'd4, 32'h55AD1299);
        ld(2'b10, 1'b0, 32'h10, 32'h55AD1299, 1'b0, 2, 1);
        st(2'b01, 32'h10, 32'h00008001, 1'b0, 3, 2, 32'd4, 32'h80011299);
        ld(2'b01, 1'b0, 32'h10, 32'hFFFF8001, 1'b0, 2, 1);
        // Faults: reserved size, out of range
        ld(2'b11, 1'b0, 32'h20, 32'h0, 1'b1, 1, 0);
        st(2'b11, 32'h20, 32'h1, 1'b1, 1, 0, 32'd0, 32'd0);
        ld(2'b10, 1'b0, 32'h4002, 32'h0, 1'b1, 1, 0);
        st(2'b10, 32'h4000, 32'h5, 1'b1, 1, 0, 32'd0, 32'd0);
        // Top of RAM
        st(2'b10, 32'h3FFC, 32'h11223344, 1'b0, 2, 1, 32'hFFF, 32'h11223344);
        ld(2'b10, 1'b0, 32'h3FFC, 32'h11223344, 1'b0, 2, 1);
        ld(2'b00, 1'b1, 32'h3FFF, 32'h00000044, 1'b0, 2, 1);
        // Misalignment
        st(2'b10, 32'h4, 32'hCAFEF00D, 1'b0, 2, 1, 32'd1, 32'hCAFEF00D);
`ifdef MEM_MISALIGN_TRAP_EN
        ld(2'b10, 1'b0, 32'h6, 32'h0, 1'b1, 1, 0);
        ld(2'b01, 1'b0, 32'h5, 32'h0, 1'b1, 1, 0);
        st(2'b01, 32'h7, 32'hBEEF, 1'b1, 1, 0, 32'd0, 32'd0);
        ld(2'b10, 1'b0, 32'h4, 32'hCAFEF00D, 1'b0, 2, 1);
`else
        ld(2'b10, 1'b0, 32'h6, 32'hCAFEF00D, 1'b0, 2, 1);
        ld(2'b01, 1'b0, 32'h5, 32'hFFFFCAFE, 1'b0, 2, 1);
        st(2'b01, 32'h7, 32'hBEEF, 1'b0, 3, 2, 32'd1, 32'hCAFEBEEF);
        ld(2'b10, 1'b0, 32'h4, 32'hCAFEBEEF, 1'b0, 2, 1);
`endif

        // Reset in the middle of an SB write cycle
        wait_ready(ok);
        ignore_bus = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h8; req_wdata = 32'h77;
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        t = 0;
        @(negedge CLK);
        while (!(mem_cs && mem_rw) && t < 10) begin
            @(negedge CLK);
            t++;
        end
        chk("sb_reached_wr", {31'd0, mem_cs & mem_rw}, 32'd1);
        Rst = 1'b1;
        #1;
        chk("abort_cs", {31'd0, mem_cs}, 32'd0);
        chk("abort_rw", {31'd0, mem_rw}, 32'd0);
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("abort_rdata", resp_rdata, 32'd0);
        chk("abort_mem_addr", mem_addr, 32'd0);
        @(negedge CLK);
        Rst = 1'b0;
        cs_cnt = 0;
        ignore_bus = 1'b0;
        repeat (5) @(negedge CLK);
        ld(2'b10, 1'b0, 32'h10, 32'h80011299, 1'b0, 2, 1);

        t = 0;
        while (resp_q.size() != 0 && t < 50) begin
            @(negedge CLK);
            t++;
        end
        chk("pending_resp", resp_q.size(), 32'd0);
        chk("pending_writes", wr_q.size(), 32'd0);
        repeat (3) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
